// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the writeback arbiter.
// Source indices, source count and the discard register.
package wb_arbiter_pkg;

  localparam int NSRC = 3;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_LD  = 2'd2
  } src_e;

  function automatic src_e rr_next(input src_e s);
    unique case (s)
      SRC_ALU: rr_next = SRC_MUL;
      SRC_MUL: rr_next = SRC_LD;
      default: rr_next = SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO, DEPTH entries of W bits.
// Ports: push/din in, pop/dout out, full/empty, vld/tag expose live entries.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int TW    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           vld,
  output logic [DEPTH-1:0][TW-1:0]   tag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE_P = AW'(1);
  localparam logic [AW:0]   ONE_C = (AW+1)'(1);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic push_ok, pop_ok;

  assign full  = (cnt_q == FULL_C);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rptr_q];

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = din;
      wptr_d = wptr_q + ONE_P;
    end
    if (pop_ok) rptr_d = rptr_q + ONE_P;
    if (push_ok && !pop_ok) cnt_d = cnt_q + ONE_C;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - ONE_C;
  end

  // slot i is live when its distance from the read pointer is below the count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off    = AW'(i) - rptr_q;
      vld[i] = ({1'b0, off} < cnt_q);
      tag[i] = mem_q[i][TW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: three source FIFOs into one RF write port.
// Ports: src_valid/ready/addr/data per source, registered wr_*, pend_mask.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NSRC-1:0]             src_valid,
  output logic [NSRC-1:0]             src_ready,
  input  logic [NSRC-1:0][4:0]        src_addr,
  input  logic [NSRC-1:0][DATA_W-1:0] src_data,
  output logic                        wr_en,
  output logic [4:0]                  wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [31:0]                 pend_mask
);

  localparam int PW = DATA_W + 5;

  logic [NSRC-1:0][PW-1:0]           head;
  logic [NSRC-1:0]                   full;
  logic [NSRC-1:0]                   empty;
  logic [NSRC-1:0]                   pop;
  logic [NSRC-1:0][DEPTH-1:0]        fvld;
  logic [NSRC-1:0][DEPTH-1:0][4:0]   ftag;

  src_e last_q, last_d;
  logic wr_en_q, wr_en_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic gnt_vld;
  src_e gnt_src;
  src_e cand;
  logic [PW-1:0] win;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (PW),
      .TW    (5)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (src_valid[i]),
      .pop   (pop[i]),
      .din   ({src_data[i], src_addr[i]}),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .vld   (fvld[i]),
      .tag   (ftag[i])
    );
  end

  assign src_ready = ~full;

  // search starts one past the last winner
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_ALU;
    cand    = rr_next(last_q);
    for (int k = 0; k < NSRC; k++) begin
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_src = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt_src] = 1'b1;
    win       = head[gnt_src];
    last_d    = gnt_vld ? gnt_src : last_q;
    // a ZERO_REG entry still uses the slot but never writes
    wr_en_d   = gnt_vld && (win[4:0] != ZERO_REG);
    wr_addr_d = gnt_vld ? win[4:0] : wr_addr_q;
    wr_data_d = gnt_vld ? win[PW-1:5] : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= SRC_LD;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // live FIFO entries plus the write in the output register
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (fvld[i][j]) pend_mask[ftag[i][j]] = 1'b1;
      end
    end
    if (wr_en_q) pend_mask[wr_addr_q] = 1'b1;
    pend_mask[ZERO_REG] = 1'b0;
  end

endmodule
